// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W     = 32;
    localparam int MEM_ARB_DATA_W     = 32;
    localparam int MEM_ARB_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT_IF = 2'd1,
        ARB_WAIT_LS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// One-cycle update latency; no backpressure.
module arb_sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; LS priority with IF anti-starvation, one outstanding txn.
// Grant is combinational in the open slot, response routed to owner on mem_rvalid; optional counters under MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ARB_ADDR_W,
    parameter int DATA_W     = MEM_ARB_DATA_W,
    parameter int STARVE_MAX = MEM_ARB_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_wr,
    input  logic [DATA_W/8-1:0] ls_mask,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_cs,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_f,
    output logic                stall_d
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_gnt,
    output logic [31:0]         perf_ls_gnt,
    output logic [31:0]         perf_conflict
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_e    state_q;
    logic [SW-1:0] starve_cnt;
    logic          run, slot_open, starve_full, if_win, ls_win, if_retire, ls_retire;

    // Every output is forced low while reset is held, even with live requests.
    assign run         = ~rst;
    assign slot_open   = run & ((state_q == ARB_IDLE) | mem_rvalid);
    assign starve_full = (starve_cnt == SW'(STARVE_MAX));
    assign if_win      = slot_open & if_req & (~ls_req | starve_full);
    assign ls_win      = slot_open & ls_req & ~if_win;

    assign if_gnt    = if_win & mem_ready;
    assign ls_gnt    = ls_win & mem_ready;
    assign mem_cs    = if_win | ls_win;
    assign mem_wr    = ls_win & ls_wr;
    assign mem_mask  = ls_win ? ls_mask  : (if_win ? '1 : '0);
    assign mem_addr  = ls_win ? ls_addr  : (if_win ? if_addr : '0);
    assign mem_wdata = ls_win ? ls_wdata : '0;

    assign if_retire = run & (state_q == ARB_WAIT_IF) & mem_rvalid;
    assign ls_retire = run & (state_q == ARB_WAIT_LS) & mem_rvalid;
    assign if_rvalid = if_retire;
    assign ls_rvalid = ls_retire;
    assign if_rdata  = if_retire ? mem_rdata : '0;
    assign ls_rdata  = ls_retire ? mem_rdata : '0;

    assign stall_f = run & if_req & ~if_retire;
    assign stall_d = run & ((ls_req & ~ls_gnt) | ((state_q == ARB_WAIT_LS) & ~mem_rvalid));

    // A new grant in the retire cycle takes precedence over returning to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else if (if_gnt) begin
            state_q <= ARB_WAIT_IF;
        end else if (ls_gnt) begin
            state_q <= ARB_WAIT_LS;
        end else if (if_retire | ls_retire) begin
            state_q <= ARB_IDLE;
        end
    end

    arb_sat_counter #(.WIDTH(SW), .MAX(SW'(STARVE_MAX))) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (slot_open & if_req & ~if_gnt),
        .clr (if_gnt | ~if_req),
        .cnt (starve_cnt)
    );

`ifdef MEM_ARB_PERF_EN
    arb_sat_counter #(.WIDTH(32)) u_perf_if (
        .clk (clk), .rst (rst), .inc (if_gnt), .clr (1'b0), .cnt (perf_if_gnt)
    );
    arb_sat_counter #(.WIDTH(32)) u_perf_ls (
        .clk (clk), .rst (rst), .inc (ls_gnt), .clr (1'b0), .cnt (perf_ls_gnt)
    );
    arb_sat_counter #(.WIDTH(32)) u_perf_cf (
        .clk (clk), .rst (rst), .inc (slot_open & if_req & ls_req), .clr (1'b0), .cnt (perf_conflict)
    );
`endif

endmodule
